// File: rtl/program_mem_if.sv
// Load/fetch port bundle for program_mem_ctrl.
// The slave side is the controller; the master side drives loads and fetches.
interface program_mem_if #(
    parameter int INS_W  = 12,
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic              load_valid;
    logic [INS_W-1:0]  load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   load_count;
    logic [INS_W-1:0]  load_sum;
    logic              busy;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [INS_W-1:0]  ins;
    logic              ins_valid;

    modport slave (
        input  load_start, load_base, load_valid, load_data, load_last,
               fetch_en, fetch_addr,
        output load_ready, load_done, load_err, load_count, load_sum, busy,
               ins, ins_valid
    );

    modport master (
        output load_start, load_base, load_valid, load_data, load_last,
               fetch_en, fetch_addr,
        input  load_ready, load_done, load_err, load_count, load_sum, busy,
               ins, ins_valid
    );
endinterface

// File: rtl/program_mem_ctrl.sv
// Program memory with a streaming load session (IDLE/LOAD/DONE) and a
// registered single-cycle fetch port that is only served while idle.
module program_mem_ctrl #(
    parameter int INS_W  = 12,
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    program_mem_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wptr_q, wptr_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [INS_W-1:0]   sum_q, sum_d;
    logic               err_q, err_d;
    logic [INS_W-1:0]   ins_q, ins_d;
    logic               ins_vld_q, ins_vld_d;
    logic               hs;

    // Contents are deliberately left unreset so a reset mid-load keeps the
    // words already written.
    logic [INS_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            err_q     <= 1'b0;
            ins_q     <= '0;
            ins_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
            ins_q     <= ins_d;
            ins_vld_q <= ins_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        err_d   = err_q;
        hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    wptr_d  = bus.load_base;
                    cnt_d   = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (bus.load_valid) begin
                    hs     = 1'b1;
                    wptr_d = wptr_q + PTR_ONE;
                    cnt_d  = cnt_q + CNT_ONE;
                    sum_d  = sum_q + bus.load_data;
                    // A last word that also fills the array still closes normally.
                    if (bus.load_last) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fetch reads the pre-edge contents; no write can coincide since writes
    // only happen in LOAD.
    always_comb begin
        ins_d     = '0;
        ins_vld_d = 1'b0;
        if (state_q == IDLE && bus.fetch_en) begin
            ins_d     = mem[bus.fetch_addr];
            ins_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) mem[wptr_q] <= bus.load_data;
    end

    assign bus.load_ready = (state_q == LOAD);
    assign bus.load_done  = (state_q == DONE) && !err_q;
    assign bus.load_err   = (state_q == DONE) &&  err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.load_count = cnt_q;
    assign bus.load_sum   = sum_q;
    assign bus.ins        = ins_q;
    assign bus.ins_valid  = ins_vld_q;
endmodule

// File: tb/tb_program_mem_ctrl.sv
// Scoreboard bench for program_mem_ctrl: directed loads/fetches push expected
// results; a negedge monitor pops and compares whenever the DUT presents one.
module tb_program_mem_ctrl;
    typedef struct packed {
        logic        err;
        logic [8:0]  cnt;
        logic [11:0] sum;
    } sess_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [11:0] fq[$];
    sess_t       sq[$];

    program_mem_if #(.INS_W(12), .ADDR_W(8)) bus ();

    program_mem_ctrl #(.INS_W(12), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [11:0] exp);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = a;
        fq.push_back(exp);
        tick();
        bus.fetch_en   = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] base);
        bus.load_start = 1'b1;
        bus.load_base  = base;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
    endtask

    // Drops valid, then lets DONE pass so the block is IDLE again.
    task automatic end_words();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        tick();
    endtask

    task automatic expect_sess(input logic err, input logic [8:0] cnt, input logic [11:0] sum);
        sess_t s;
        s.err = err;
        s.cnt = cnt;
        s.sum = sum;
        sq.push_back(s);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.load_ready), 0);
        chk({tag, "_done"},  32'(bus.load_done),  0);
        chk({tag, "_err"},   32'(bus.load_err),   0);
        chk({tag, "_busy"},  32'(bus.busy),       0);
        chk({tag, "_ivld"},  32'(bus.ins_valid),  0);
        chk({tag, "_ins"},   32'(bus.ins),        0);
        chk({tag, "_cnt"},   32'(bus.load_count), 0);
        chk({tag, "_sum"},   32'(bus.load_sum),   0);
    endtask

    // Monitor: every presented result must match the head of its queue;
    // an idle fetch port must read back zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ins_valid) begin
                if (fq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_unexpected: got ins %h with nothing expected", bus.ins);
                end else begin
                    chk("fetch_ins", 32'(bus.ins), 32'(fq.pop_front()));
                end
            end else begin
                chk("idle_ins_zero", 32'(bus.ins), 0);
            end
            if (bus.load_done || bus.load_err) begin
                if (sq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sess_unexpected: done=%0b err=%0b with nothing expected",
                             bus.load_done, bus.load_err);
                end else begin
                    sess_t e;
                    e = sq.pop_front();
                    chk("sess_done", 32'(bus.load_done), 32'(!e.err));
                    chk("sess_err",  32'(bus.load_err),  32'(e.err));
                    chk("sess_cnt",  32'(bus.load_count), 32'(e.cnt));
                    chk("sess_sum",  32'(bus.load_sum),   32'(e.sum));
                end
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        #1;
        check_all_zero("rst");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic session, then fetch the middle word.
        start_load(8'h10);
        expect_sess(1'b0, 9'd3, 12'h006);
        chk("load_ready_in_load", 32'(bus.load_ready), 1);
        chk("busy_in_load",       32'(bus.busy),       1);
        send_word(12'h001, 1'b0);
        send_word(12'h002, 1'b0);
        send_word(12'h003, 1'b1);
        chk("ready_in_done", 32'(bus.load_ready), 0);
        end_words();
        chk("busy_after_done", 32'(bus.busy), 0);
        fetch(8'h11, 12'h002);

        // Sum wraps at INS_W bits.
        start_load(8'h40);
        expect_sess(1'b0, 9'd2, 12'h001);
        send_word(12'hFFF, 1'b0);
        send_word(12'h002, 1'b1);
        end_words();
        chk("sum_held", 32'(bus.load_sum), 32'h001);

        // Write pointer wraps past the top of the array.
        start_load(8'hFE);
        expect_sess(1'b0, 9'd3, 12'h331);
        send_word(12'hAAA, 1'b0);
        send_word(12'hBBB, 1'b0);
        send_word(12'hCCC, 1'b1);
        end_words();
        fetch(8'hFE, 12'hAAA);
        fetch(8'hFF, 12'hBBB);
        fetch(8'h00, 12'hCCC);

        // Fetch and load_start together: fetch sees pre-load contents.
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 8'h10;
        fq.push_back(12'h001);
        start_load(8'h10);
        bus.fetch_en   = 1'b0;
        expect_sess(1'b0, 9'd1, 12'h777);
        send_word(12'h777, 1'b1);
        end_words();
        fetch(8'h10, 12'h777);

        // Fetch held across a session is served only once IDLE returns.
        start_load(8'h50);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 8'h50;
        fq.push_back(12'h123);
        expect_sess(1'b0, 9'd1, 12'h123);
        send_word(12'h123, 1'b1);
        end_words();
        tick();
        bus.fetch_en = 1'b0;

        // Overflow: 256 words, no last, data = i ^ 5A5, sum = 12'hF80.
        start_load(8'h00);
        expect_sess(1'b1, 9'd256, 12'hF80);
        for (int i = 0; i < 256; i++) send_word(12'(i) ^ 12'h5A5, 1'b0);
        end_words();
        tick();
        chk("ovf_cnt_held", 32'(bus.load_count), 256);
        chk("ovf_idle_ready", 32'(bus.load_ready), 0);
        fetch(8'h00, 12'h5A5);
        fetch(8'h80, 12'h525);
        fetch(8'hFF, 12'h55A);

        // Reset mid-session: outputs clear, written words survive.
        start_load(8'h20);
        send_word(12'h3C1, 1'b0);
        send_word(12'h3C2, 1'b0);
        bus.load_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_idle", 32'(bus.busy), 0);
        fetch(8'h20, 12'h3C1);
        fetch(8'h21, 12'h3C2);

        repeat (3) tick();
        chk("fetch_queue_drained", 32'(fq.size()), 0);
        chk("sess_queue_drained",  32'(sq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
